// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: op classes, condition codes and FSM states.
package instr_encoder_pkg;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] AL = 4'hE;
    localparam logic [3:0] EQ = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: decoded instruction fields -> 32-bit ARM word plus a legal flag.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [3:0]  i_cond,
    input  logic [1:0]  i_op,
    input  logic [5:0]  i_funct,
    input  logic [3:0]  i_rn,
    input  logic [3:0]  i_rd,
    input  logic [11:0] i_src2,
    input  logic [23:0] i_imm24,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_op)
            OP_DP, OP_MEM: o_word = {i_cond, i_op, i_funct, i_rn, i_rd, i_src2};
            // Branch: bit 25 is fixed high, funct[4] carries the link bit.
            OP_BR:         o_word = {i_cond, 2'b10, 1'b1, i_funct[4], i_imm24};
            default:       o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder / program loader: packs field beats and writes them to imem.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_cond,
    input  logic [1:0]        in_op,
    input  logic [5:0]        in_funct,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [11:0]       in_src2,
    input  logic [23:0]       in_imm24,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_count;
    logic [31:0]         r_wd;
    logic                r_last;
    logic                r_err_ill;
    logic                r_err_ovf;
    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_accept;
    logic                w_full;

    instr_pack u_pack (
        .i_cond  (in_cond),
        .i_op    (in_op),
        .i_funct (in_funct),
        .i_rn    (in_rn),
        .i_rd    (in_rd),
        .i_src2  (in_src2),
        .i_imm24 (in_imm24),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign w_accept = (r_state == ST_LOAD) && in_valid;
    assign w_full   = (r_ptr == PTR_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_next = ST_LOAD;
            ST_LOAD: begin
                if (w_accept) begin
                    if (w_legal)      w_next = ST_WRITE;
                    else if (in_last) w_next = ST_DONE;
                end
            end
            ST_WRITE: w_next = (r_last || w_full) ? ST_DONE : ST_LOAD;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_count   <= '0;
            r_wd      <= '0;
            r_last    <= 1'b0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_ptr     <= '0;
                        r_count   <= '0;
                        r_last    <= 1'b0;
                        r_err_ill <= 1'b0;
                        r_err_ovf <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_wd   <= w_word;
                            r_last <= in_last;
                        end else begin
                            r_err_ill <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    // Every completed write counts; the pointer only advances when more words follow.
                    r_count <= r_count + CNT_ONE;
                    if (!r_last) begin
                        if (w_full) r_err_ovf <= 1'b1;
                        else        r_ptr     <= r_ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (r_state == ST_LOAD);
    assign imem_we      = (r_state == ST_WRITE);
    assign busy         = (r_state == ST_LOAD) || (r_state == ST_WRITE);
    assign done         = (r_state == ST_DONE);
    assign imem_addr    = r_ptr;
    assign imem_wd      = r_wd;
    assign word_count   = r_count;
    assign err_illegal  = r_err_ill;
    assign err_overflow = r_err_ovf;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming instruction encoder and program loader for the single-cycle ARM core. It accepts decoded instruction fields (cond, op class, funct, registers, immediates) over a valid/ready handshake and packs them into 32-bit ARM words, producing the same field layout the core's decode and condition logic consume. It writes the words into instruction memory at consecutive word addresses, and benches and the boot path use it to build programs without a hex file.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a new load; clears address pointer and status; honoured only in IDLE or DONE
- in_valid  in  1  field beat valid
- in_ready  out  1  encoder can accept a beat this cycle
- in_last  in  1  beat is the final instruction of the program
- in_cond  in  4  condition field, bits [31:28]
- in_op  in  2  00 data-processing, 01 memory, 10 branch, 11 illegal
- in_funct  in  6  bits [25:20] for op 00/01; for op 10, funct[4] is the L bit
- in_rn  in  4  bits [19:16]
- in_rd  in  4  bits [15:12]
- in_src2  in  12  bits [11:0] (imm12 or shifted-register field)
- in_imm24  in  24  branch offset, bits [23:0]
- imem_we  out  1  one-cycle write strobe
- imem_addr  out  ADDR_W  word address of imem_wd
- imem_wd  out  32  encoded instruction
- busy  out  1  state is LOAD or WRITE
- done  out  1  state is DONE
- word_count  out  ADDR_W+1  words written since the last start
- err_illegal  out  1  sticky: an op=11 beat was dropped
- err_overflow  out  1  sticky: memory was full before in_last

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE, start=1 -> LOAD. The pointer, word_count and both error flags clear.
- LOAD: in_ready=1. A beat completes when in_valid&&in_ready.
  - A legal beat registers the encoded word and goes to WRITE.
  - An illegal beat (op=11) sets err_illegal and writes nothing. With in_last it goes to DONE; otherwise it stays in LOAD.
- Encoding:
  - op 00/01: {cond, op, funct, rn, rd, src2}
  - op 10: {cond, 2'b10, 1'b1, funct[4], imm24}
- WRITE: imem_we=1 for exactly one cycle at the current pointer, with in_ready=0. The next state is chosen on the following edge, in priority order:
  - in_last latched -> DONE
  - pointer == 2^ADDR_W-1 -> DONE and set err_overflow
  - otherwise -> LOAD, with pointer+1 and word_count+1
- On the DONE exits, word_count still increments. word_count therefore reaches 2^ADDR_W on a full load, which is why it has the extra bit. The pointer never wraps.
- start is ignored in LOAD and WRITE.
- Reset mid-operation aborts immediately: imem_we drops asynchronously and no partial word is retained.

## Timing
- Reset values:
  - state IDLE, in_ready 0, imem_we 0
  - imem_addr 0, imem_wd 0, word_count 0
  - busy 0, done 0, err_illegal 0, err_overflow 0
- Latency: accepting beat at edge N -> imem_we high during cycle N+1 with registered addr/data.
- Throughput: one word per 2 cycles. in_ready is low during WRITE.
- All outputs are registered or decoded from the state register; there is no combinational path from in_* to outputs.
- start at edge N -> in_ready=1 in cycle N+1.
- done is a level signal and holds until the next start.

## Structure
- The shared core package holds:
  - op-class constants: OP_DP=2'b00, OP_MEM=2'b01, OP_BR=2'b10
  - the state enum
  - cond constants: AL=4'hE, EQ=4'h0
- Sub-module instr_pack is a pure combinational field->word packer with a legal flag. It is reused by the bench's scoreboard.

## Test plan
- ADD R1,R2,#5: cond=E, op=00, funct=101000, rn=2, rd=1, src2=005 -> imem_we at addr 0 with wd=0xE2821005, 1 cycle after acceptance.
- STR R3,[R4,#8]: op=01, funct=011000, rn=4, rd=3, src2=008, sent as the 2nd beat with in_last -> addr 1, wd=0xE5843008, then done=1 and word_count=2.
- BEQ, cond=0, op=10, funct[4]=0, imm24=FFFFFE -> wd=0x0AFFFFFE. With funct[4]=1 -> 0x0BFFFFFE.
- op=11 beat between two legal beats -> err_illegal=1, no write for it, legal words land at consecutive addrs 0 and 1.
- ADDR_W=2, 5 beats with no in_last:
  - exactly 4 writes at addrs 0..3
  - err_overflow=1, done=1, word_count=4
  - 5th beat never accepted (in_ready=0)
- reset asserted during WRITE -> imem_we falls without a clock edge, all outputs at reset values. Subsequent start reloads from addr 0.
